dfm_spi_master: RTL
===================

# dfm_spi_master

Host-side SPI mode-0 master for the digital frequency meter's command/register link, driving SCLK, MOSI, CS_n and the D/C line, and sampling MISO. A single transaction is one command byte sent with D/C low, followed by 0-31 data bytes sent with D/C high while read-back bytes are captured. The block sits in host/test FPGA logic (or a bench harness) opposite the meter's SPI slave and register interface. It supplies gate-time writes and measurement read-back without software bit-banging.

## Interface
- CLK_DIV, 4, clk_i cycles per SCLK half-period; legal range 1..255
- clk_i  in  1  system clock
- rst_i  in  1  reset; asynchronous assert, active-high
- xfer_start_i  in  1  start request, sampled only when xfer_busy_o=0
- xfer_cmd_i  in  8  command byte, latched on accept
- xfer_len_i  in  5  data-byte count after the command, latched on accept
- xfer_busy_o  out  1  transaction in progress, including the CS gap
- xfer_done_o  out  1  one-cycle pulse when CS_n deasserts
- tx_data_i  in  8  next data byte
- tx_vld_i  in  1  tx_data_i valid
- tx_rdy_o  out  1  master requests a data byte; transfer on tx_vld_i & tx_rdy_o
- rx_data_o  out  8  last received data-phase byte, held until the next capture
- rx_vld_o  out  1  one-cycle pulse, rx_data_o updated
- spi_sclk_o  out  1  SPI clock, idle low
- spi_mosi_o  out  1  SPI data out, MSB first
- spi_cs_n_o  out  1  chip select, active low
- spi_miso_i  in  1  SPI data in
- dc_o  out  1  0 = command byte, 1 = data byte

## Operation
- States: IDLE, SHIFT, LOAD, HOLD, GAP.
- IDLE: when xfer_start_i=1, latch cmd and len, then go to SHIFT. On the next cycle: cs_n=0, busy=1, dc=0, mosi=cmd[7], bit counter=7.
- SHIFT: each bit is CLK_DIV cycles with sclk low, then CLK_DIV cycles with sclk high.
  - MISO is sampled into the rx shift register on the cycle sclk rises.
  - When sclk falls, the next bit is driven on mosi.
  - The 8th falling edge ends the byte. Go to LOAD if bytes remain, otherwise HOLD.
- LOAD: tx_rdy_o=1, sclk=0, cs_n held low, dc/mosi unchanged.
  - On handshake: shift register=tx_data_i, dc=1, mosi=tx_data_i[7], then go to SHIFT.
  - If tx_vld_i stays low, stall indefinitely; CS is not released.
- HOLD: CLK_DIV cycles with sclk low. Then cs_n=1 and xfer_done_o pulses in that same cycle, and the block enters GAP.
- GAP: CLK_DIV cycles with cs_n high and busy=1, then IDLE (busy=0).
- The receive path discards bytes shifted in during the command byte.
  - On the 8th falling edge of each data byte: rx_data_o = captured byte, rx_vld_o=1 for one cycle.
- xfer_len_i=0 sends the command only: tx_rdy_o and rx_vld_o never assert.
- xfer_start_i while busy is ignored; it is not queued.
- Bit/half-period counters saturate-free. The divider counter is $clog2(CLK_DIV+1) bits wide and the data-byte counter is 5 bits; the byte count never wraps.

## Timing
- Reset values:
  - spi_cs_n_o=1; all other outputs 0.
  - This covers spi_sclk_o, spi_mosi_o, dc_o, xfer_busy_o, xfer_done_o, tx_rdy_o, rx_vld_o and rx_data_o=8'h00.
- Reset mid-transaction: outputs take reset values immediately (CS_n high asynchronously), and the state returns to IDLE. No xfer_done_o pulse.
- Accept-to-CS_n-low latency: 1 cycle.
- First sclk rise: CLK_DIV cycles after cs_n falls, which gives MOSI setup of CLK_DIV cycles.
- Byte time: 16*CLK_DIV cycles.
- LOAD costs 1 cycle when tx_vld_i is already high.
- CS_n low duration with no stalls: CLK_DIV*(16*(N+1)+1) + N cycles, for N data bytes.
- tx_rdy_o is never asserted outside LOAD. It is combinationally independent of tx_vld_i.
- dc_o changes only at a byte boundary, while sclk is low.

## Configuration
- DFM_SPI_MASTER_LOOPBACK_EN:
  - Defined: the receive shift register samples spi_mosi_o in place of spi_miso_i, and spi_miso_i is unused. This is for self-test.
  - Undefined: spi_miso_i is sampled. All other behaviour is identical.

## Test plan
- Command only, CLK_DIV=2: cmd=8'hA5, len=0 -> 8 sclk pulses, MOSI 1,0,1,0,0,1,0,1, dc=0 throughout, cs_n low for 34 cycles, one done pulse, no tx_rdy/rx_vld.
- Write with tx_vld held high, CLK_DIV=2: cmd=8'h01, len=2, data 8'h12, 8'h34 -> dc rises at byte 1, MOSI matches, 24 sclk pulses, cs_n low for 100 cycles.
- Read: slave model returns 8'hC3, 8'h5A on MISO in the data phase -> two rx_vld pulses with rx_data_o=8'hC3 then 8'h5A; the command-phase byte is not reported.
- Stall: withhold tx_vld_i for 20 cycles in LOAD -> sclk stays low, cs_n stays low, tx_rdy_o stays high; the transfer resumes intact after tx_vld_i.
- Reset at bit 3 of a data byte -> cs_n=1 and sclk=0 in the same cycle, no done pulse; a subsequent transaction is correct.
- LOOPBACK_EN defined: len=1, data 8'h96 -> rx_data_o=8'h96. Also: xfer_start_i pulsed during busy/GAP -> ignored.

Source files
------------

// File: rtl/dfm_spi_master.sv
// SPI mode-0 master for the frequency meter link: one command byte (dc=0) then 0-31 data bytes (dc=1).
// Define DFM_SPI_MASTER_LOOPBACK_EN to sample spi_mosi_o instead of spi_miso_i (self-test).
module dfm_spi_master #(
  parameter int CLK_DIV = 4
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       xfer_start_i,
  input  logic [7:0] xfer_cmd_i,
  input  logic [4:0] xfer_len_i,
  output logic       xfer_busy_o,
  output logic       xfer_done_o,
  input  logic [7:0] tx_data_i,
  input  logic       tx_vld_i,
  output logic       tx_rdy_o,
  output logic [7:0] rx_data_o,
  output logic       rx_vld_o,
  output logic       spi_sclk_o,
  output logic       spi_mosi_o,
  output logic       spi_cs_n_o,
  input  logic       spi_miso_i,
  output logic       dc_o
);

  localparam int DIV_W = $clog2(CLK_DIV + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  typedef enum logic [2:0] {IDLE, SHIFT, LOAD, HOLD, GAP} state_t;

  state_t           state, state_n;
  logic [DIV_W-1:0] div_cnt, div_cnt_n;
  logic [2:0]       bit_cnt, bit_cnt_n;
  logic [4:0]       bytes_left, bytes_left_n;
  logic [7:0]       tx_sr, tx_sr_n;
  logic [7:0]       rx_sr, rx_sr_n;
  logic [7:0]       rx_data, rx_data_n;
  logic             sclk, sclk_n;
  logic             mosi, mosi_n;
  logic             cs_n, cs_n_n;
  logic             dc, dc_n;
  logic             busy, busy_n;
  logic             done, done_n;
  logic             rx_vld, rx_vld_n;
  logic             rx_bit;

`ifdef DFM_SPI_MASTER_LOOPBACK_EN
  assign rx_bit = mosi;
`else
  assign rx_bit = spi_miso_i;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state      <= IDLE;
      div_cnt    <= '0;
      bit_cnt    <= '0;
      bytes_left <= '0;
      tx_sr      <= '0;
      rx_sr      <= '0;
      rx_data    <= '0;
      sclk       <= 1'b0;
      mosi       <= 1'b0;
      cs_n       <= 1'b1;
      dc         <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      rx_vld     <= 1'b0;
    end else begin
      state      <= state_n;
      div_cnt    <= div_cnt_n;
      bit_cnt    <= bit_cnt_n;
      bytes_left <= bytes_left_n;
      tx_sr      <= tx_sr_n;
      rx_sr      <= rx_sr_n;
      rx_data    <= rx_data_n;
      sclk       <= sclk_n;
      mosi       <= mosi_n;
      cs_n       <= cs_n_n;
      dc         <= dc_n;
      busy       <= busy_n;
      done       <= done_n;
      rx_vld     <= rx_vld_n;
    end
  end

  always_comb begin
    state_n      = state;
    div_cnt_n    = div_cnt;
    bit_cnt_n    = bit_cnt;
    bytes_left_n = bytes_left;
    tx_sr_n      = tx_sr;
    rx_sr_n      = rx_sr;
    rx_data_n    = rx_data;
    sclk_n       = sclk;
    mosi_n       = mosi;
    cs_n_n       = cs_n;
    dc_n         = dc;
    busy_n       = busy;
    done_n       = 1'b0;
    rx_vld_n     = 1'b0;
    case (state)
      IDLE: begin
        if (xfer_start_i) begin
          state_n      = SHIFT;
          tx_sr_n      = xfer_cmd_i;
          bytes_left_n = xfer_len_i;
          mosi_n       = xfer_cmd_i[7];
          bit_cnt_n    = 3'd7;
          div_cnt_n    = '0;
          sclk_n       = 1'b0;
          cs_n_n       = 1'b0;
          busy_n       = 1'b1;
          dc_n         = 1'b0;
        end
      end
      SHIFT: begin
        if (div_cnt != DIV_LAST) begin
          div_cnt_n = div_cnt + 1'b1;
        end else begin
          div_cnt_n = '0;
          if (!sclk) begin
            sclk_n  = 1'b1;
            rx_sr_n = {rx_sr[6:0], rx_bit};
          end else begin
            sclk_n = 1'b0;
            if (bit_cnt == 3'd0) begin
              // Command-phase bytes are shifted in but never reported.
              if (dc) begin
                rx_data_n = rx_sr;
                rx_vld_n  = 1'b1;
              end
              if (bytes_left != 5'd0) begin
                bytes_left_n = bytes_left - 5'd1;
                state_n      = LOAD;
              end else begin
                state_n = HOLD;
              end
            end else begin
              bit_cnt_n = bit_cnt - 3'd1;
              tx_sr_n   = {tx_sr[6:0], 1'b0};
              mosi_n    = tx_sr[6];
            end
          end
        end
      end
      LOAD: begin
        // CS stays asserted for as long as the producer stalls.
        if (tx_vld_i) begin
          tx_sr_n   = tx_data_i;
          mosi_n    = tx_data_i[7];
          dc_n      = 1'b1;
          bit_cnt_n = 3'd7;
          div_cnt_n = '0;
          state_n   = SHIFT;
        end
      end
      HOLD: begin
        if (div_cnt != DIV_LAST) begin
          div_cnt_n = div_cnt + 1'b1;
        end else begin
          div_cnt_n = '0;
          cs_n_n    = 1'b1;
          done_n    = 1'b1;
          state_n   = GAP;
        end
      end
      GAP: begin
        if (div_cnt != DIV_LAST) begin
          div_cnt_n = div_cnt + 1'b1;
        end else begin
          div_cnt_n = '0;
          busy_n    = 1'b0;
          state_n   = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign tx_rdy_o    = (state == LOAD);
  assign xfer_busy_o = busy;
  assign xfer_done_o = done;
  assign rx_data_o   = rx_data;
  assign rx_vld_o    = rx_vld;
  assign spi_sclk_o  = sclk;
  assign spi_mosi_o  = mosi;
  assign spi_cs_n_o  = cs_n;
  assign dc_o        = dc;

endmodule
